// File: rtl/qubit_gate_sequencer_if.sv
// Job/result handshake bundle for the Pauli gate sequencer: a Q8.8 state plus
// a program goes in, the transformed state and a saturation flag come out.
interface qubit_gate_sequencer_if #(
  parameter int MAX_OPS = 8,
  parameter int LEN_W   = $clog2(MAX_OPS + 1)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*MAX_OPS-1:0]   prog;
  logic [LEN_W-1:0]       prog_len;
  logic [15:0]            alpha_re, alpha_im, beta_re, beta_im;
  logic                   out_valid;
  logic                   out_ready;
  logic [15:0]            out_alpha_re, out_alpha_im, out_beta_re, out_beta_im;
  logic                   out_sat;
  logic                   busy;

  modport slave (
    input  in_valid, prog, prog_len, alpha_re, alpha_im, beta_re, beta_im, out_ready,
    output in_ready, out_valid, out_alpha_re, out_alpha_im, out_beta_re, out_beta_im,
           out_sat, busy
  );

  modport master (
    output in_valid, prog, prog_len, alpha_re, alpha_im, beta_re, beta_im, out_ready,
    input  in_ready, out_valid, out_alpha_re, out_alpha_im, out_beta_re, out_beta_im,
           out_sat, busy
  );
endinterface

// File: rtl/qubit_gate_sequencer.sv
// Applies up to MAX_OPS Pauli gates (NOP/X/Z/Y) to one Q8.8 qubit state, one
// gate per clock. Each gate is a lane permutation followed by per-lane negation.

// One amplitude lane: optional saturating negation (-0x8000 -> 0x7FFF).
module qgs_neg_lane #(
  parameter int VEC_W = 16
) (
  input  logic [VEC_W-1:0] x,
  input  logic             neg,
  output logic [VEC_W-1:0] y,
  output logic             sat
);
  logic is_min;
  assign is_min = (x == {1'b1, {(VEC_W-1){1'b0}}});
  assign sat    = neg & is_min;
  always_comb begin
    y = x;
    if (neg) y = is_min ? {1'b0, {(VEC_W-1){1'b1}}} : (~x + 1'b1);
  end
endmodule

module qubit_gate_sequencer #(
  parameter int MAX_OPS = 8,
  parameter int LEN_W   = $clog2(MAX_OPS + 1)
) (
  input logic                  clk,
  input logic                  reset,
  qubit_gate_sequencer_if.slave io
);
  localparam int NUM_LANES = 4;   // 0:a_re 1:a_im 2:b_re 3:b_im
  localparam int VEC_W     = 16;
  localparam int IDX_W     = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_X   = 2'b01;
  localparam logic [1:0] OP_Z   = 2'b10;
  localparam logic [1:0] OP_Y   = 2'b11;

  logic [1:0]                          fsm_q, fsm_d;
  logic [LEN_W-1:0]                    idx_q, idx_d, len_q, len_d;
  logic [MAX_OPS-1:0][1:0]             prog_q, prog_d;
  logic [NUM_LANES-1:0][VEC_W-1:0]     st_q, st_d, out_q, out_d;
  logic                                sat_q, sat_d, out_sat_q, out_sat_d;

  logic [1:0]                          op;
  logic [NUM_LANES-1:0][VEC_W-1:0]     src, nxt, in_vec;
  logic [NUM_LANES-1:0]                neg, lane_sat;
  logic [LEN_W-1:0]                    len_clamp;

  assign in_vec    = {io.beta_im, io.beta_re, io.alpha_im, io.alpha_re};
  assign len_clamp = (io.prog_len > LEN_W'(MAX_OPS)) ? LEN_W'(MAX_OPS) : io.prog_len;
  assign op        = prog_q[idx_q[IDX_W-1:0]];

  // Gate = routing of source lanes plus a negate mask; Y routes b into a with
  // a sign flip on a_im and a into b with a sign flip on b_re.
  always_comb begin
    src = st_q;
    neg = '0;
    case (op)
      OP_X: src = {st_q[1], st_q[0], st_q[3], st_q[2]};
      OP_Z: neg = 4'b1100;
      OP_Y: begin
        src = {st_q[0], st_q[1], st_q[2], st_q[3]};
        neg = 4'b0110;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    qgs_neg_lane #(.VEC_W(VEC_W)) u_lane (
      .x   (src[i]),
      .neg (neg[i]),
      .y   (nxt[i]),
      .sat (lane_sat[i])
    );
  end

  always_comb begin
    fsm_d     = fsm_q;
    idx_d     = idx_q;
    len_d     = len_q;
    prog_d    = prog_q;
    st_d      = st_q;
    sat_d     = sat_q;
    out_d     = out_q;
    out_sat_d = out_sat_q;
    case (fsm_q)
      S_IDLE: if (io.in_valid) begin
        st_d   = in_vec;
        prog_d = io.prog;
        idx_d  = '0;
        sat_d  = 1'b0;
        len_d  = len_clamp;
        if (len_clamp == '0) begin
          fsm_d     = S_DONE;
          out_d     = in_vec;
          out_sat_d = 1'b0;
        end else begin
          fsm_d = S_RUN;
        end
      end
      S_RUN: begin
        st_d  = nxt;
        sat_d = sat_q | (|lane_sat);
        idx_d = idx_q + 1'b1;
        if (idx_q == len_q - LEN_W'(1)) begin
          fsm_d     = S_DONE;
          out_d     = nxt;
          out_sat_d = sat_d;
        end
      end
      S_DONE: if (io.out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      prog_q    <= '0;
      st_q      <= '0;
      sat_q     <= 1'b0;
      out_q     <= '0;
      out_sat_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      prog_q    <= prog_d;
      st_q      <= st_d;
      sat_q     <= sat_d;
      out_q     <= out_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign io.in_ready     = (fsm_q == S_IDLE);
  assign io.out_valid    = (fsm_q == S_DONE);
  assign io.busy         = (fsm_q == S_RUN);
  assign io.out_sat      = out_sat_q;
  assign io.out_alpha_re = out_q[0];
  assign io.out_alpha_im = out_q[1];
  assign io.out_beta_re  = out_q[2];
  assign io.out_beta_im  = out_q[3];
endmodule

// File: doc/qubit_gate_sequencer.md
# qubit_gate_sequencer

Sequencer that applies a short program of single-qubit Pauli gates (NOP/X/Y/Z) to one Q8.8 complex qubit state, one gate per clock, through a shared internal gate datapath. It accepts a job (state plus program) over a valid/ready handshake, runs it, and presents the transformed state over a valid/ready handshake. It sits between the state source (register file or test harness) and downstream consumers of the gate-layer datapath.

## Interface
- MAX_OPS, 8: maximum program length; program slots are 2 bits each.
- LEN_W, $clog2(MAX_OPS+1): width of prog_len.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  job offered.
- in_ready  out  1  sequencer can accept a job.
- prog  in  2*MAX_OPS  opcodes; slot k = prog[2k+1:2k], slot 0 executes first.
- prog_len  in  LEN_W  number of slots to execute, 0..MAX_OPS.
- alpha_re, alpha_im, beta_re, beta_im  in  16 each, signed Q8.8  input amplitudes.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_alpha_re, out_alpha_im, out_beta_re, out_beta_im  out  16 each, signed Q8.8  result amplitudes.
- out_sat  out  1  at least one negation in this job saturated.
- busy  out  1  high in RUN.

## Operation
- Opcodes: 00 NOP (state unchanged); 01 X: a'=b, b'=a; 10 Z: a'=a, b'=-b; 11 Y: a'=(b_im, -b_re), b'=(-a_im, a_re), written as (re, im).
- Negation is saturating: -16'h8000 = 16'h7FFF and sets the job's sat flag; every other value is exact two's-complement negation. No other arithmetic is performed.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid: latch the amplitudes into the state register, latch prog, set idx=0, clear sat, and latch L = min(prog_len, MAX_OPS). Go to RUN if L>0, otherwise go to DONE.
  - RUN: each cycle, apply slot idx to the state register and increment idx. After the edge that applies slot L-1, go to DONE.
  - DONE: out_valid=1 and the outputs show the state register. On out_ready, go to IDLE.
- in_ready is high only in IDLE. in_valid in RUN or DONE is ignored, and no job is queued.
- Output amplitudes and out_sat are registered and hold their value outside DONE. They change only when a job completes; downstream should treat them as meaningful only with out_valid.
- prog_len > MAX_OPS is clamped to MAX_OPS. Slots at or beyond L are never executed.

## Timing
- Reset values: state IDLE; in_ready=1; out_valid=0; busy=0; out_sat=0; all output amplitudes 16'h0000; idx=0.
- The accept edge is the rising edge where in_valid and in_ready are both high.
- out_valid rises L+1 edges after the accept edge, counting the accept edge itself. L=0 gives out_valid on the cycle immediately after the accept edge.
- busy is high for exactly L cycles per job.
- The result handshake completes on an edge where out_valid and out_ready are both high.
  - out_valid falls and in_ready rises on that same edge.
  - The next job can be accepted one edge later at the earliest.
  - Throughput is one job per L+2 cycles.
- If out_ready is low in DONE, the outputs and out_valid hold indefinitely.
- Reset asserted in any state, including mid-RUN or in DONE: on the next edge the block returns to reset values. The in-flight job is discarded and never produces out_valid.
- If reset and in_valid are high on the same edge, reset wins and no job is accepted.

## Test plan
- Reset: hold reset for 2 cycles, then release. Required: out_valid=0, busy=0, out_sat=0, all outputs 0000, and in_ready=1 on the first cycle after release.
- X on |0>: a=(0100,0000), b=(0000,0000), prog_len=1, slot0=01. Required: out_valid exactly 2 edges after accept; out a=(0000,0000), b=(0100,0000); out_sat=0.
- Complex program: a=(0080,FF80), b=(0040,00C0), prog slots X,Z,X, prog_len=3. Required: out_valid 4 edges after accept; out a=(FF80,0080), b=(0040,00C0); busy high for 3 cycles.
- Y and clamp: a=(0100,0000), b=0, prog_len=MAX_OPS+5 with slot0=11 and the remaining slots 00. Required: result a=(0000,0000), b=(0000,0100); busy high for exactly MAX_OPS cycles.
- Saturation and zero-length jobs:
  - b=(8000,0000), prog Z, prog_len=1. Required: out b_re=7FFF, out_sat=1.
  - Next job with prog_len=0. Required: inputs pass through unchanged, out_valid 1 edge after accept, out_sat=0.
- Backpressure and mid-run reset:
  - Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid. Required: outputs and out_valid stable, in_ready=0, no second job accepted.
  - Then start a prog_len=8 job and assert reset during RUN cycle 3. Required: out_valid never rises, all outputs 0000, in_ready=1 next cycle.
